// File: rtl/lsu_pkg.sv
// lsu_pkg: shared size encodings, FSM states and alignment check for the load/store port
package lsu_pkg;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;
  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;
  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] lo);
    return (size == SZ_H && lo[0]) || (size == SZ_W && lo[1:0] != 2'd0) || (size == SZ_D && lo != 3'd0);
  endfunction
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: store lane merge and load lane extraction with sign/zero extension
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [63:0] i_old,
  input  logic [63:0] i_wdata,
  input  logic [2:0]  i_lane,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [63:0] i_rdata,
  output logic [63:0] o_merged,
  output logic [63:0] o_load
);
  logic [5:0]  w_sh;
  logic [63:0] w_mask;
  logic [63:0] w_raw;
  logic        w_sign;
  // field mask at lane 0, shifted into place for merge; top mask bit picks the sign
  always_comb begin
    w_sh     = {i_lane, 3'b000};
    w_mask   = i_size == SZ_B ? 64'hFF : i_size == SZ_H ? 64'hFFFF : i_size == SZ_W ? 64'hFFFF_FFFF : '1;
    o_merged = (i_old & ~(w_mask << w_sh)) | ((i_wdata & w_mask) << w_sh);
    w_raw    = (i_rdata >> w_sh) & w_mask;
    w_sign   = !i_unsigned && |(w_raw & (w_mask ^ (w_mask >> 1)));
    o_load   = w_raw | (w_sign ? ~w_mask : '0);
  end
endmodule

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: sized byte-addressed load/store requests to doubleword memory bus cycles
module lsu_mem_port
  import lsu_pkg::*;
#(
  parameter int IDX_W  = 12,
  parameter int IO_BIT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  output logic [63:0] rsp_data,
  output logic        rsp_fault,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic        mem_wr,
  input  logic [63:0] mem_rdata
);
  state_t      r_state, w_next;
  logic        r_we, r_uns, r_rsp_fault;
  logic [1:0]  r_size;
  logic [63:0] r_addr, r_wdata, r_old, r_rsp_data;
  logic        w_accept, w_req_fault, w_unused;
  logic [2:0]  w_lane;
  logic [63:0] w_merged, w_load;
  assign w_accept    = r_state == IDLE && req_valid;
  assign w_req_fault = misaligned(req_size, req_addr[2:0]);
  assign w_lane      = r_addr[IO_BIT] ? 3'd0 : r_addr[2:0];
  assign w_unused    = ^r_addr;
  lsu_lane_align u_align (
    .i_old      (r_old),
    .i_wdata    (r_wdata),
    .i_lane     (w_lane),
    .i_size     (r_size),
    .i_unsigned (r_uns),
    .i_rdata    (mem_rdata),
    .o_merged   (w_merged),
    .o_load     (w_load)
  );
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  // faults skip the bus; full-width and IO stores need no read-back
  always_comb begin
    w_next = r_state == IDLE ? (!req_valid ? IDLE : w_req_fault ? RESP :
                                (req_we && (req_size == SZ_D || req_addr[IO_BIT])) ? WR : RD)
           : r_state == RD ? (r_we ? WR : RESP)
           : r_state == WR ? RESP : IDLE;
  end
  // bus and handshake outputs decoded from state
  always_comb begin
    req_ready = r_state == IDLE;
    rsp_valid = r_state == RESP;
    mem_wr    = r_state == WR;
    mem_addr  = r_state == IDLE ? '0 : 64'({r_addr[IO_BIT], r_addr[IDX_W+2:3]});
    mem_wdata = r_state == WR ? w_merged : '0;
    rsp_data  = r_rsp_data;
    rsp_fault = r_rsp_fault;
  end
  // request latch, read-back capture (zero when no read, so direct stores merge onto 0) and response regs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we        <= 1'b0;
      r_uns       <= 1'b0;
      r_size      <= SZ_B;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_old       <= '0;
      r_rsp_data  <= '0;
      r_rsp_fault <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we    <= req_we;
        r_uns   <= req_unsigned;
        r_size  <= req_size;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_old   <= '0;
      end else if (r_state == RD) r_old <= mem_rdata;
      r_rsp_data  <= (r_state == RD && !r_we) ? w_load : '0;
      r_rsp_fault <= w_accept && w_req_fault;
    end
  end
endmodule

// File: tb/tb_lsu_mem_port.sv
// tb_lsu_mem_port: directed plus randomized load/store checks against a byte-level reference memory
module tb_lsu_mem_port;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [63:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_fault, mem_wr;
  logic [63:0] rsp_data, mem_addr, mem_wdata, mem_rdata;
  logic [63:0] mem [0:8191];
  logic [63:0] ref_mem [0:8191];
  int          checks = 0, failures = 0;
  logic [63:0] last_wd, last_ma, last_data;
  logic        last_fault;

  lsu_mem_port dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_fault(rsp_fault), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 8192; i++) mem[i] = '0;
  always @(posedge clk) if (mem_wr) mem[mem_addr[12:0]] <= mem_wdata;
  assign mem_rdata = mem[mem_addr[12:0]];

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic txn(input bit we, input bit [1:0] sz, input bit uns, input logic [63:0] addr, input logic [63:0] wd);
    bit          io, flt;
    int          idx, lane, nb, exp_rsp, exp_wr, wr_at, rsp_at, k;
    logic [63:0] mask, exp_word, raw, exp_load;
    io   = addr[15];
    idx  = int'({io, addr[14:3]});
    lane = io ? 0 : int'(addr[2:0]);
    nb   = 1 << sz;
    flt  = (addr % nb) != 0;
    mask = (sz == 2'd3) ? '1 : ((64'd1 << (8 * nb)) - 64'd1);
    exp_word = ref_mem[idx];
    if (we && !flt) begin
      if (io) exp_word = wd & mask;
      else for (int i = 0; i < nb; i++) exp_word[8*(lane+i) +: 8] = wd[8*i +: 8];
    end
    raw = (ref_mem[idx] >> (8 * lane)) & mask;
    if (!uns && sz != 2'd3 && raw[8*nb-1]) raw = raw | ~mask;
    exp_load = (we || flt) ? '0 : raw;
    exp_rsp = flt ? 1 : !we ? 2 : (sz == 2'd3 || io) ? 2 : 3;
    exp_wr  = (!we || flt) ? 0 : (sz == 2'd3 || io) ? 1 : 2;
    @(negedge clk);
    chk("idle_ready", 64'(req_ready), 64'd1);
    chk("idle_rsp_data", rsp_data, 64'd0);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
    req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
    k = 1; wr_at = 0; rsp_at = 0; last_ma = '0; last_wd = '0; last_data = '0; last_fault = 1'b0;
    while (rsp_at == 0 && k <= 6) begin
      if (mem_wr) begin
        if (wr_at == 0) begin wr_at = k; last_ma = mem_addr; last_wd = mem_wdata; end
        else wr_at = 99;
      end
      if (rsp_valid) begin rsp_at = k; last_data = rsp_data; last_fault = rsp_fault; end
      else begin @(negedge clk); k++; end
    end
    chk("rsp_latency", 64'(rsp_at), 64'(exp_rsp));
    chk("wr_cycle", 64'(wr_at), 64'(exp_wr));
    if (exp_wr != 0 && wr_at == exp_wr) begin
      chk("mem_addr", last_ma, 64'(idx));
      chk("mem_wdata", last_wd, exp_word);
    end
    chk("rsp_data", last_data, exp_load);
    chk("rsp_fault", 64'(last_fault), 64'(flt));
    if (we && !flt) ref_mem[idx] = exp_word;
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) ref_mem[i] = '0;
    #12;
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_mem_wr", 64'(mem_wr), 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_mem_wdata", mem_wdata, 64'd0);
    chk("rst_rsp", {rsp_data[62:0], rsp_fault}, 64'd0);
    @(negedge clk); rst_n = 1'b1;

    txn(1, 2'd3, 0, 64'h40, 64'h1122334455667788);
    chk("plan_sd_addr", last_ma, 64'd8);
    txn(0, 2'd3, 0, 64'h40, 64'h0);
    chk("plan_ld_data", last_data, 64'h1122334455667788);
    txn(1, 2'd0, 0, 64'h43, 64'hAB);
    chk("plan_sb_merge", last_wd, 64'h11223344AB667788);
    txn(0, 2'd0, 0, 64'h43, 64'h0);
    chk("plan_lb_signed", last_data, 64'hFFFFFFFFFFFFFFAB);
    txn(0, 2'd0, 1, 64'h43, 64'h0);
    chk("plan_lbu", last_data, 64'h00000000000000AB);
    txn(0, 2'd1, 0, 64'h41, 64'h0);
    chk("plan_fault", 64'(last_fault), 64'd1);
    txn(1, 2'd0, 0, 64'h8000, 64'hFFFF_0000_0000_005A);
    chk("plan_io_addr", last_ma, 64'h1000);
    chk("plan_io_byte", 64'(last_wd[7:0]), 64'h5A);
    txn(1, 2'd0, 0, 64'h8000, 64'h3C);
    txn(0, 2'd0, 1, 64'h8000, 64'h0);
    chk("plan_io_load", last_data, 64'h3C);

    // abort a read-modify-write store while it is reading
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0; req_addr = 64'h48; req_wdata = 64'h77;
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_rd_addr", mem_addr, 64'd9);
    rst_n = 1'b0;
    #1;
    chk("abort_ready", 64'(req_ready), 64'd1);
    chk("abort_outs", {mem_addr[61:0], mem_wr, rsp_valid}, 64'd0);
    chk("abort_data", mem_wdata | rsp_data | 64'(rsp_fault), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_quiet", 64'({mem_wr, rsp_valid}), 64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_release_ready", 64'(req_ready), 64'd1);
    txn(0, 2'd3, 0, 64'h48, 64'h0);

    // abort while the write strobe is high: it must drop before the edge
    txn(1, 2'd3, 0, 64'h50, 64'hDEADBEEFCAFEF00D);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd1; req_addr = 64'h52; req_wdata = 64'h1234;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("abort_wr_high", 64'(mem_wr), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_wr_drop", 64'(mem_wr), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    txn(0, 2'd3, 0, 64'h50, 64'h0);
    chk("abort_wr_mem", last_data, 64'hDEADBEEFCAFEF00D);

    for (int n = 0; n < 60; n++) begin
      logic [63:0] a;
      bit          io;
      io = ($urandom_range(0, 4) == 0);
      a  = io ? (64'h8000 | 64'($urandom_range(0, 1) * 8) | 64'($urandom_range(0, 7)))
              : (64'($urandom_range(8, 11) * 8) | 64'($urandom_range(0, 7)));
      txn(1'($urandom), 2'($urandom), 1'($urandom), a, {$urandom, $urandom});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
